if_fetch_unit: RTL and testbench

Instruction-fetch stage, directly upstream of the IF/ID pipeline register. Owns the program counter and drives a single-port instruction-memory interface with a ready handshake. Presents {PC+4, instruction} to IF/ID each cycle. Holds a fetched word in a skid register while the pipeline is frozen, and redirects on a taken branch resolved in ID.

---
 rtl/if_fetch_unit.sv | 110 +++++++++++
 tb/tb_if_fetch_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a single-port imem with a
// same-cycle ready, delivers {PC+4, instruction} to IF/ID, parks a fetched
// word in a skid register while frozen, and redirects on a taken branch.
module if_fetch_unit #(
  parameter int unsigned          WORD_LEN = 32,
  parameter logic [WORD_LEN-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [WORD_LEN-1:0] branch_target,
  input  logic [WORD_LEN-1:0] imem_rdata,
  input  logic                imem_ready,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  output logic [WORD_LEN-1:0] PC,
  output logic [WORD_LEN-1:0] instruction,
  output logic                inst_valid,
  output logic [31:0]         fetch_count
);

  typedef enum logic {REQ, HOLD} state_t;

  // IF/ID-facing bundle, built in one place so reset can squash it whole.
  typedef struct packed {
    logic                vld;
    logic [WORD_LEN-1:0] pc4;
    logic [WORD_LEN-1:0] inst;
  } fetch_rsp_t;

  state_t              state, state_nx;
  logic [WORD_LEN-1:0] pc_reg, pc_nx;
  logic [WORD_LEN-1:0] hold_reg, hold_nx;
  logic [WORD_LEN-1:0] next_pc;
  logic [31:0]         cnt_q;
  logic                cnt_en;
  logic                req;
  fetch_rsp_t          rsp;

  // Address comes straight from the register: freeze/branch only steer
  // what gets loaded, so they never reach imem_addr combinationally.
  assign imem_addr = pc_reg;
  assign next_pc   = pc_reg + WORD_LEN'(4);

  // Next-state and output decode; branch overrides freeze on the state update.
  always_comb begin
    state_nx = state;
    pc_nx    = pc_reg;
    hold_nx  = hold_reg;
    req      = 1'b0;
    rsp      = '0;
    unique case (state)
      REQ: begin
        req = 1'b1;
        if (imem_ready) begin
          rsp = '{vld: 1'b1, pc4: next_pc, inst: imem_rdata};
          if (!freeze) begin
            pc_nx = next_pc;
          end else begin
            hold_nx  = imem_rdata;
            state_nx = HOLD;
          end
        end
      end
      HOLD: begin
        rsp = '{vld: 1'b1, pc4: next_pc, inst: hold_reg};
        if (!freeze) begin
          pc_nx    = next_pc;
          state_nx = REQ;
        end
      end
      default: state_nx = REQ;
    endcase
    // Redirect: the current word is squashed by IF/ID flush, drop any skid.
    if (branch_taken) begin
      pc_nx    = branch_target;
      state_nx = REQ;
      hold_nx  = '0;
    end
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    imem_req    = req & ~rst;
    inst_valid  = rsp.vld & ~rst;
    PC          = rst ? '0 : rsp.pc4;
    instruction = rst ? '0 : rsp.inst;
  end

  // A word counts only when IF/ID actually accepts it.
  assign cnt_en      = inst_valid & ~freeze & ~branch_taken;
  assign fetch_count = cnt_q;

  // State, PC, skid register and accepted-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= REQ;
      pc_reg   <= RESET_PC;
      hold_reg <= '0;
      cnt_q    <= '0;
    end else begin
      state    <= state_nx;
      pc_reg   <= pc_nx;
      hold_reg <= hold_nx;
      if (cnt_en) cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: stream, ready stalls, freeze/skid,
// branch during hold, reset mid-hold and PC wrap.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken, imem_ready;
  logic [31:0] branch_target, imem_rdata, rdata_ovr;
  logic        use_model;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, pc, instruction, fetch_count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Memory model: each word is its own address tagged with 0xA in the top nibble.
  assign imem_rdata = use_model ? (imem_addr | 32'hA000_0000) : rdata_ovr;

  // {imem_req, inst_valid, imem_addr, PC, instruction}
  wire [97:0] obs = {imem_req, inst_valid, imem_addr, pc, instruction};

  if_fetch_unit #(.WORD_LEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .PC(pc), .instruction(instruction), .inst_valid(inst_valid),
    .fetch_count(fetch_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_ready = 1'b1; use_model = 1'b1; rdata_ovr = '0;
    tick();
    #1;
    nvec++;
    if ({imem_req, inst_valid, pc, instruction} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      nerr++; $display("FAIL reset_outputs got=%h exp=%h",
                       {imem_req, inst_valid, pc, instruction}, {1'b0, 1'b0, 32'h0, 32'h0});
    end
    tick();
    rst = 1'b0;
    #1;
    nvec++;
    if ({imem_addr, fetch_count} !== {32'h0, 32'h0}) begin
      nerr++; $display("FAIL reset_state got=%h exp=%h", {imem_addr, fetch_count}, 64'h0);
    end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 32'(i * 4);
      #1;
      nvec++;
      if (obs !== {1'b1, 1'b1, a, a + 32'h4, a | 32'hA000_0000}) begin
        nerr++; $display("FAIL stream%0d got=%h exp=%h", i, obs,
                         {1'b1, 1'b1, a, a + 32'h4, a | 32'hA000_0000});
      end
      tick();
    end
    nvec++;
    if ({imem_addr, fetch_count} !== {32'hC, 32'd3}) begin
      nerr++; $display("FAIL stream_count got=%h exp=%h", {imem_addr, fetch_count}, {32'hC, 32'd3});
    end
  endtask

  task automatic test_ready_stall();
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      nvec++;
      if ({obs, fetch_count} !== {1'b1, 1'b0, 32'hC, 32'h0, 32'h0, 32'd3}) begin
        nerr++; $display("FAIL ready_bubble%0d got=%h exp=%h", i, {obs, fetch_count},
                         {1'b1, 1'b0, 32'hC, 32'h0, 32'h0, 32'd3});
      end
      tick();
    end
    imem_ready = 1'b1;
    #1;
    nvec++;
    if (obs !== {1'b1, 1'b1, 32'hC, 32'h10, 32'hA000_000C}) begin
      nerr++; $display("FAIL ready_resume got=%h exp=%h", obs,
                       {1'b1, 1'b1, 32'hC, 32'h10, 32'hA000_000C});
    end
    tick();
    nvec++;
    if ({imem_addr, fetch_count} !== {32'h10, 32'd4}) begin
      nerr++; $display("FAIL ready_advance got=%h exp=%h", {imem_addr, fetch_count}, {32'h10, 32'd4});
    end
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    #1;
    nvec++;
    if (obs !== {1'b1, 1'b1, 32'h10, 32'h14, 32'hA000_0010}) begin
      nerr++; $display("FAIL freeze_capture got=%h exp=%h", obs,
                       {1'b1, 1'b1, 32'h10, 32'h14, 32'hA000_0010});
    end
    tick();
    use_model = 1'b0; rdata_ovr = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      #1;
      nvec++;
      if ({obs, fetch_count} !== {1'b0, 1'b1, 32'h10, 32'h14, 32'hA000_0010, 32'd4}) begin
        nerr++; $display("FAIL freeze_hold%0d got=%h exp=%h", i, {obs, fetch_count},
                         {1'b0, 1'b1, 32'h10, 32'h14, 32'hA000_0010, 32'd4});
      end
      tick();
    end
    freeze = 1'b0;
    #1;
    nvec++;
    if (obs !== {1'b0, 1'b1, 32'h10, 32'h14, 32'hA000_0010}) begin
      nerr++; $display("FAIL freeze_release got=%h exp=%h", obs,
                       {1'b0, 1'b1, 32'h10, 32'h14, 32'hA000_0010});
    end
    tick();
    use_model = 1'b1;
    #1;
    nvec++;
    if ({imem_req, imem_addr, fetch_count} !== {1'b1, 32'h14, 32'd5}) begin
      nerr++; $display("FAIL freeze_after got=%h exp=%h", {imem_req, imem_addr, fetch_count},
                       {1'b1, 32'h14, 32'd5});
    end
  endtask

  task automatic test_branch_hold();
    freeze = 1'b1;
    tick();
    branch_taken = 1'b1; branch_target = 32'h40;
    #1;
    nvec++;
    if (obs !== {1'b0, 1'b1, 32'h14, 32'h18, 32'hA000_0014}) begin
      nerr++; $display("FAIL branch_hold_out got=%h exp=%h", obs,
                       {1'b0, 1'b1, 32'h14, 32'h18, 32'hA000_0014});
    end
    tick();
    branch_taken = 1'b0; freeze = 1'b0;
    #1;
    nvec++;
    if ({obs, fetch_count} !== {1'b1, 1'b1, 32'h40, 32'h44, 32'hA000_0040, 32'd5}) begin
      nerr++; $display("FAIL branch_redirect got=%h exp=%h", {obs, fetch_count},
                       {1'b1, 1'b1, 32'h40, 32'h44, 32'hA000_0040, 32'd5});
    end
    tick();
    nvec++;
    if ({imem_addr, fetch_count} !== {32'h44, 32'd6}) begin
      nerr++; $display("FAIL branch_next got=%h exp=%h", {imem_addr, fetch_count}, {32'h44, 32'd6});
    end
  endtask

  task automatic test_reset_mid_hold();
    freeze = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    nvec++;
    if ({imem_req, inst_valid, pc, instruction} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      nerr++; $display("FAIL rst_hold_outputs got=%h exp=%h",
                       {imem_req, inst_valid, pc, instruction}, {1'b0, 1'b0, 32'h0, 32'h0});
    end
    tick();
    rst = 1'b0; freeze = 1'b0;
    #1;
    nvec++;
    if ({obs, fetch_count} !== {1'b1, 1'b1, 32'h0, 32'h4, 32'hA000_0000, 32'd0}) begin
      nerr++; $display("FAIL rst_hold_after got=%h exp=%h", {obs, fetch_count},
                       {1'b1, 1'b1, 32'h0, 32'h4, 32'hA000_0000, 32'd0});
    end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    #1;
    nvec++;
    if ({obs, fetch_count} !== {1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 32'd0}) begin
      nerr++; $display("FAIL wrap_word got=%h exp=%h", {obs, fetch_count},
                       {1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 32'd0});
    end
    tick();
    nvec++;
    if ({imem_addr, fetch_count} !== {32'h0, 32'd1}) begin
      nerr++; $display("FAIL wrap_next got=%h exp=%h", {imem_addr, fetch_count}, {32'h0, 32'd1});
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_ready_stall();
    test_freeze();
    test_branch_hold();
    test_reset_mid_hold();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
